// File: rtl/eth_link_manager_if.sv
// Status and control bundle between eth_link_manager and its GT/PCS channels.
// Carries link_drop_count only when ETH_LINK_STATS_EN is defined.
interface eth_link_manager_if #(
  parameter int CHANNELS = 1
);
  logic                    clock_ok;
  logic [CHANNELS-1:0]     gt_powergood;
  logic [CHANNELS-1:0]     gt_reset_done;
  logic [CHANNELS-1:0]     rx_block_lock;
  logic [CHANNELS-1:0]     rx_high_ber;
  logic [CHANNELS-1:0]     force_reset;
  logic [CHANNELS-1:0]     gt_reset_all;
  logic [CHANNELS-1:0]     link_up;
  logic [3*CHANNELS-1:0]   link_state;
  logic [CHANNELS-1:0]     retry_exhausted;
`ifdef ETH_LINK_STATS_EN
  logic [8*CHANNELS-1:0]   link_drop_count;

  modport master (
    input  clock_ok, gt_powergood, gt_reset_done, rx_block_lock, rx_high_ber, force_reset,
    output gt_reset_all, link_up, link_state, retry_exhausted, link_drop_count
  );
  modport slave (
    output clock_ok, gt_powergood, gt_reset_done, rx_block_lock, rx_high_ber, force_reset,
    input  gt_reset_all, link_up, link_state, retry_exhausted, link_drop_count
  );
`else
  modport master (
    input  clock_ok, gt_powergood, gt_reset_done, rx_block_lock, rx_high_ber, force_reset,
    output gt_reset_all, link_up, link_state, retry_exhausted
  );
  modport slave (
    output clock_ok, gt_powergood, gt_reset_done, rx_block_lock, rx_high_ber, force_reset,
    input  gt_reset_all, link_up, link_state, retry_exhausted
  );
`endif
endinterface

// File: rtl/eth_link_manager.sv
// N-channel GT bring-up sequencer and link supervisor (POR, reset-done, block lock, debounce, retry).
// Optional macro ETH_LINK_STATS_EN adds per-channel 8-bit saturating link-drop counters.
module eth_link_manager #(
  parameter int CHANNELS     = 1,
  parameter int POR_CYCLES   = 1024,
  parameter int LOCK_TIMEOUT = 12500000,
  parameter int DOWN_FILTER  = 16,
  parameter int RETRY_LIMIT  = 0
) (
  input  logic               clock,
  input  logic               aresetn,
  eth_link_manager_if.master bus
);

  localparam int TMAX_A = (POR_CYCLES > LOCK_TIMEOUT) ? POR_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > DOWN_FILTER) ? TMAX_A : DOWN_FILTER;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW     = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

  localparam logic [TW-1:0] POR_LAST  = TW'(POR_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  // The sample that moved UP into S_DOWN_FILTER is the first bad one of the run.
  localparam logic [TW-1:0] DF_LAST   = (DOWN_FILTER >= 2) ? TW'(DOWN_FILTER - 2) : '0;
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_POR         = 3'd1,
    S_WAIT_DONE   = 3'd2,
    S_WAIT_LOCK   = 3'd3,
    S_UP          = 3'd4,
    S_DOWN_FILTER = 3'd5,
    S_FAILED      = 3'd6
  } state_t;

  function automatic logic [RW-1:0] retry_inc(input logic [RW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] drop_inc(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t        st, st_nx;
    logic [TW-1:0] tmr, tmr_nx;
    logic [RW-1:0] rc, rc_nx, rc_up;
    logic          retry;
    logic          lock_ok;
    logic          done;

    assign lock_ok = bus.rx_block_lock[i] & ~bus.rx_high_ber[i];
    assign done    = bus.gt_reset_done[i];
    assign rc_up   = retry_inc(rc);

    always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
        st  <= S_IDLE;
        tmr <= '0;
        rc  <= '0;
      end else begin
        st  <= st_nx;
        tmr <= tmr_nx;
        rc  <= rc_nx;
      end
    end

    always_comb begin
      st_nx  = st;
      tmr_nx = tmr;
      rc_nx  = rc;
      retry  = 1'b0;
      if (!bus.clock_ok || !bus.gt_powergood[i]) begin
        st_nx  = S_IDLE;
        tmr_nx = '0;
        rc_nx  = '0;
      end else if (bus.force_reset[i]) begin
        st_nx  = S_POR;
        tmr_nx = '0;
        rc_nx  = '0;
      end else begin
        case (st)
          S_IDLE: begin
            st_nx  = S_POR;
            tmr_nx = '0;
          end
          S_POR: begin
            if (tmr == POR_LAST) begin
              st_nx  = S_WAIT_DONE;
              tmr_nx = '0;
            end else begin
              tmr_nx = tmr + 1'b1;
            end
          end
          S_WAIT_DONE: begin
            if (done) begin
              st_nx  = S_WAIT_LOCK;
              tmr_nx = '0;
            end else if (tmr == LOCK_LAST) begin
              retry = 1'b1;
            end else begin
              tmr_nx = tmr + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (lock_ok) begin
              st_nx = S_UP;
              rc_nx = '0;
            end else if (!done || tmr == LOCK_LAST) begin
              retry = 1'b1;
            end else begin
              tmr_nx = tmr + 1'b1;
            end
          end
          S_UP: begin
            if (!lock_ok) begin
              if (DOWN_FILTER == 1) begin
                retry = 1'b1;
              end else begin
                st_nx  = S_DOWN_FILTER;
                tmr_nx = '0;
              end
            end else if (!done) begin
              retry = 1'b1;
            end
          end
          S_DOWN_FILTER: begin
            if (lock_ok) begin
              st_nx = S_UP;
            end else if (tmr == DF_LAST || !done) begin
              retry = 1'b1;
            end else begin
              tmr_nx = tmr + 1'b1;
            end
          end
          S_FAILED: begin
          end
          default: begin
            st_nx  = S_IDLE;
            tmr_nx = '0;
          end
        endcase
      end

      // Every failure path funnels through here so counting and the FAILED decision live in one place.
      if (retry) begin
        rc_nx  = rc_up;
        tmr_nx = '0;
        st_nx  = (RETRY_LIMIT != 0 && rc_up == RETRY_MAX) ? S_FAILED : S_POR;
      end
    end

    assign bus.gt_reset_all[i]     = (st == S_IDLE) || (st == S_POR) || (st == S_FAILED);
    assign bus.link_up[i]          = (st == S_UP);
    assign bus.retry_exhausted[i]  = (st == S_FAILED);
    assign bus.link_state[3*i +: 3] = st;

`ifdef ETH_LINK_STATS_EN
    logic       drop;
    logic [7:0] drop_cnt;

    // A retry out of the debounce state, or a bad-lock retry straight from UP, is a lost link.
    assign drop = retry & ((st == S_DOWN_FILTER) | ((st == S_UP) & ~lock_ok));

    always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
        drop_cnt <= '0;
      end else if (drop) begin
        drop_cnt <= drop_inc(drop_cnt);
      end
    end

    assign bus.link_drop_count[8*i +: 8] = drop_cnt;
`endif
  end

endmodule

// File: tb/tb_eth_link_manager.sv
// Self-checking bench for eth_link_manager: directed vector table, hand sequences and a randomized run
// against a cycle-level behavioural model. Stats checks are active when ETH_LINK_STATS_EN is defined.
module tb_eth_link_manager;

  localparam int CH = 2;
  localparam int POR = 8;
  localparam int LT = 32;
  localparam int DF = 16;
  localparam int RL = 3;

  localparam int S_IDLE = 0, S_POR = 1, S_WD = 2, S_WL = 3, S_UP = 4, S_DF = 5, S_FAIL = 6;

  logic clock;
  logic aresetn;
  int   vectors = 0;
  int   miscompares = 0;

  eth_link_manager_if #(.CHANNELS(CH)) bus ();

  eth_link_manager #(
    .CHANNELS(CH), .POR_CYCLES(POR), .LOCK_TIMEOUT(LT), .DOWN_FILTER(DF), .RETRY_LIMIT(RL)
  ) dut (
    .clock(clock),
    .aresetn(aresetn),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model: dwell counts and bad-run lengths per channel
  int m_st [CH];
  int m_dw [CH];
  int m_rt [CH];
  int m_bad [CH];
  int m_drop [CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_st[c] = S_IDLE; m_dw[c] = 0; m_rt[c] = 0; m_bad[c] = 0; m_drop[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < CH; c++) begin
      bit ok, pg, dn, good, frc, rtry, drp;
      ok = bus.clock_ok; pg = bus.gt_powergood[c]; dn = bus.gt_reset_done[c];
      good = bus.rx_block_lock[c] && !bus.rx_high_ber[c]; frc = bus.force_reset[c];
      rtry = 0; drp = 0;
      if (!ok || !pg) begin
        m_st[c] = S_IDLE; m_rt[c] = 0; m_dw[c] = 0;
      end else if (frc) begin
        m_st[c] = S_POR; m_rt[c] = 0; m_dw[c] = 0;
      end else begin
        case (m_st[c])
          S_IDLE: begin m_st[c] = S_POR; m_dw[c] = 0; end
          S_POR: begin
            m_dw[c]++;
            if (m_dw[c] == POR) begin m_st[c] = S_WD; m_dw[c] = 0; end
          end
          S_WD: begin
            m_dw[c]++;
            if (dn) begin m_st[c] = S_WL; m_dw[c] = 0; end
            else if (m_dw[c] == LT) rtry = 1;
          end
          S_WL: begin
            m_dw[c]++;
            if (good) begin m_st[c] = S_UP; m_rt[c] = 0; end
            else if (!dn || m_dw[c] == LT) rtry = 1;
          end
          S_UP: begin
            if (!good) begin
              m_bad[c] = 1;
              if (m_bad[c] == DF) begin rtry = 1; drp = 1; end
              else m_st[c] = S_DF;
            end else if (!dn) rtry = 1;
          end
          S_DF: begin
            if (good) m_st[c] = S_UP;
            else begin
              m_bad[c]++;
              if (m_bad[c] == DF || !dn) begin rtry = 1; drp = 1; end
            end
          end
          default: ;
        endcase
      end
      if (rtry) begin
        m_rt[c]++;
        m_dw[c] = 0;
        m_st[c] = (RL != 0 && m_rt[c] == RL) ? S_FAIL : S_POR;
      end
      if (drp && m_drop[c] < 255) m_drop[c]++;
    end
  endfunction

  // ---------------- helpers
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    if (aresetn) model_step();
    #1;
  endtask

  task automatic set_in(logic ok, logic [1:0] pg, logic [1:0] dn, logic [1:0] lk,
                        logic [1:0] ber, logic [1:0] frc);
    bus.clock_ok = ok; bus.gt_powergood = pg; bus.gt_reset_done = dn;
    bus.rx_block_lock = lk; bus.rx_high_ber = ber; bus.force_reset = frc;
  endtask

  task automatic chk_model(string tag);
    logic [1:0] ra, up, rx;
    logic [5:0] ls;
    logic [15:0] dc;
    for (int c = 0; c < CH; c++) begin
      ra[c] = (m_st[c] == S_IDLE) || (m_st[c] == S_POR) || (m_st[c] == S_FAIL);
      up[c] = (m_st[c] == S_UP);
      rx[c] = (m_st[c] == S_FAIL);
      ls[3*c +: 3] = 3'(m_st[c]);
      dc[8*c +: 8] = 8'(m_drop[c]);
    end
    chk({tag, ".gt_reset_all"}, 32'(bus.gt_reset_all), 32'(ra));
    chk({tag, ".link_up"}, 32'(bus.link_up), 32'(up));
    chk({tag, ".retry_exhausted"}, 32'(bus.retry_exhausted), 32'(rx));
    chk({tag, ".link_state"}, 32'(bus.link_state), 32'(ls));
`ifdef ETH_LINK_STATS_EN
    chk({tag, ".link_drop_count"}, 32'(bus.link_drop_count), 32'(dc));
`endif
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic ok; logic [1:0] pg, dn, lk, ber, frc; int n;
    logic [1:0] ra, up, rx; logic [5:0] ls; int d0;
  } vec_t;
  vec_t tbl [$];

  function automatic void add(logic ok, logic [1:0] pg, logic [1:0] dn, logic [1:0] lk,
                              logic [1:0] ber, logic [1:0] frc, int n,
                              logic [1:0] ra, logic [1:0] up, logic [1:0] rx,
                              int s1, int s0, int d0);
    vec_t v;
    v.ok = ok; v.pg = pg; v.dn = dn; v.lk = lk; v.ber = ber; v.frc = frc; v.n = n;
    v.ra = ra; v.up = up; v.rx = rx; v.ls = {3'(s1), 3'(s0)}; v.d0 = d0;
    tbl.push_back(v);
  endfunction

  initial begin
    int n;
    logic [1:0] lk_r;
    aresetn = 1'b0;
    set_in(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    model_reset();

    //    ok pg     dn     lk     ber    frc    n   ra     up     rx     s1 s0 d0
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1,  2'b11, 2'b00, 2'b00, 0, 0, 0);
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1,  2'b11, 2'b00, 2'b00, 1, 1, 0);
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 7,  2'b11, 2'b00, 2'b00, 1, 1, 0);
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1,  2'b00, 2'b00, 2'b00, 2, 2, 0);
    add(1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1,  2'b00, 2'b00, 2'b00, 3, 3, 0);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1,  2'b00, 2'b11, 2'b00, 4, 4, 0);
    add(1, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 1,  2'b00, 2'b10, 2'b00, 4, 5, 0);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1,  2'b00, 2'b11, 2'b00, 4, 4, 0);
    add(1, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 15, 2'b00, 2'b10, 2'b00, 4, 5, 0);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1,  2'b00, 2'b11, 2'b00, 4, 4, 0);
    add(1, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 16, 2'b01, 2'b10, 2'b00, 4, 1, 1);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 8,  2'b00, 2'b10, 2'b00, 4, 2, 1);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1,  2'b00, 2'b10, 2'b00, 4, 3, 1);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1,  2'b00, 2'b11, 2'b00, 4, 4, 1);
    add(1, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 1,  2'b01, 2'b10, 2'b00, 4, 0, 1);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1,  2'b01, 2'b10, 2'b00, 4, 1, 1);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 3,  2'b01, 2'b10, 2'b00, 4, 1, 1);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 1,  2'b01, 2'b10, 2'b00, 4, 1, 1);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 7,  2'b01, 2'b10, 2'b00, 4, 1, 1);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1,  2'b00, 2'b10, 2'b00, 4, 2, 1);
    add(0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1,  2'b11, 2'b00, 2'b00, 0, 0, 1);
    add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1,  2'b11, 2'b00, 2'b00, 1, 1, 1);

    repeat (3) @(posedge clock);
    #1;
    chk("reset.gt_reset_all", 32'(bus.gt_reset_all), 32'h3);
    chk("reset.link_up", 32'(bus.link_up), 32'h0);
    chk("reset.link_state", 32'(bus.link_state), 32'h0);
    chk("reset.retry_exhausted", 32'(bus.retry_exhausted), 32'h0);
    aresetn = 1'b1;

    foreach (tbl[k]) begin
      set_in(tbl[k].ok, tbl[k].pg, tbl[k].dn, tbl[k].lk, tbl[k].ber, tbl[k].frc);
      repeat (tbl[k].n) cycle();
      chk($sformatf("v%0d.gt_reset_all", k), 32'(bus.gt_reset_all), 32'(tbl[k].ra));
      chk($sformatf("v%0d.link_up", k), 32'(bus.link_up), 32'(tbl[k].up));
      chk($sformatf("v%0d.retry_exhausted", k), 32'(bus.retry_exhausted), 32'(tbl[k].rx));
      chk($sformatf("v%0d.link_state", k), 32'(bus.link_state), 32'(tbl[k].ls));
`ifdef ETH_LINK_STATS_EN
      chk($sformatf("v%0d.drop_count0", k), 32'(bus.link_drop_count[7:0]), 32'(tbl[k].d0));
`endif
    end

    // Retry exhaustion: both channels in POR, never reset-done -> three 8+32 cycle rounds.
    set_in(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    n = 0;
    while (bus.retry_exhausted != 2'b11 && n < 300) begin
      cycle();
      n++;
    end
    chk("fail.latency", 32'(n), 32'd120);
    chk("fail.link_state", 32'(bus.link_state), 32'o66);
    chk("fail.gt_reset_all", 32'(bus.gt_reset_all), 32'h3);
    repeat (5) cycle();
    chk("fail.hold", 32'(bus.link_state), 32'o66);
    bus.force_reset = 2'b01;
    cycle();
    bus.force_reset = 2'b00;
    chk("fail.force.link_state", 32'(bus.link_state), 32'o61);
    chk("fail.force.retry_exhausted", 32'(bus.retry_exhausted), 32'h2);
    chk("fail.force.gt_reset_all", 32'(bus.gt_reset_all), 32'h3);

`ifdef ETH_LINK_STATS_EN
    // Drive 300 drops on channel 0: one bad sample, then reset-done lost while debouncing.
    bus.gt_reset_done = 2'b11;
    bus.rx_block_lock = 2'b11;
    for (int d = 0; d < 300; d++) begin
      n = 0;
      while (!bus.link_up[0] && n < 40) begin
        cycle();
        n++;
      end
      chk($sformatf("drop%0d.bringup", d), 32'(bus.link_up[0]), 32'h1);
      bus.rx_block_lock[0] = 1'b0;
      cycle();
      bus.gt_reset_done[0] = 1'b0;
      cycle();
      bus.rx_block_lock[0] = 1'b1;
      bus.gt_reset_done[0] = 1'b1;
      if (d == 99) chk("drop.count101", 32'(bus.link_drop_count[7:0]), 32'd101);
    end
    chk("drop.saturated", 32'(bus.link_drop_count[7:0]), 32'd255);
    chk("drop.ch1", 32'(bus.link_drop_count[15:8]), 32'd0);
`endif

    // Asynchronous reset mid-POR, between clock edges.
    cycle();
    cycle();
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("areset.gt_reset_all", 32'(bus.gt_reset_all), 32'h3);
    chk("areset.link_up", 32'(bus.link_up), 32'h0);
    chk("areset.link_state", 32'(bus.link_state), 32'h0);
    chk("areset.retry_exhausted", 32'(bus.retry_exhausted), 32'h0);
`ifdef ETH_LINK_STATS_EN
    chk("areset.link_drop_count", 32'(bus.link_drop_count), 32'h0);
`endif
    cycle();
    cycle();
    aresetn = 1'b1;

    // Randomized run against the behavioural model.
    lk_r = 2'b00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int mode;
      mode = (cyc / 256) % 4;
      bus.clock_ok = ($urandom_range(0, 99) != 0);
      for (int c = 0; c < CH; c++) begin
        bus.gt_powergood[c]  = ($urandom_range(0, 59) != 0);
        bus.gt_reset_done[c] = ($urandom_range(0, mode[0] ? 999 : 9) != 0);
        if ($urandom_range(0, mode[1] ? 39 : 3) == 0) lk_r[c] = ~lk_r[c];
        bus.rx_block_lock[c] = lk_r[c];
        bus.rx_high_ber[c]   = ($urandom_range(0, 24) == 0);
        bus.force_reset[c]   = ($urandom_range(0, 99) == 0);
      end
      cycle();
      chk_model($sformatf("rnd%0d", cyc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
